// File: rtl/wb2core.sv
// wb2core: Wishbone pipelined slave to Ibex-style request/grant master bridge.
//
// Requests are forwarded combinationally to the device; responses come back
// registered one cycle after dev_rvalid, in order, one per accepted request.
// Up to MAX_OUTSTANDING (1..4) requests may be in flight. If the WB master
// drops wb_cyc with requests in flight, their responses are swallowed and new
// requests are held off until all of them have returned.
//
// Optional build macro: WB2CORE_ERR_EN
//   defined   -> dev_err returned with dev_rvalid produces wb_err (data 0)
//   undefined -> dev_err is ignored and wb_err stays 0
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   wb_cyc/stb/we/adr/sel/dat_i      WB request inputs
//   wb_dat_o, wb_ack, wb_err         WB registered response outputs
//   wb_stall                         WB flow control
//   dev_req/we/be/addr/wdata         device request outputs
//   dev_gnt                          device grant
//   dev_rvalid, dev_rdata, dev_err   device response inputs
//
// state | meaning
// IDLE  | nothing outstanding
// BUSY  | 1..MAX_OUTSTANDING requests awaiting a response
// DRAIN | wb_cyc was dropped; discarding responses still in flight

module wb2core #(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   input  logic        wb_we,
   input  logic [31:0] wb_adr,
   input  logic [3:0]  wb_sel,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack,
   output logic        wb_err,
   output logic        wb_stall,
   output logic        dev_req,
   input  logic        dev_gnt,
   output logic        dev_we,
   output logic [3:0]  dev_be,
   output logic [31:0] dev_addr,
   output logic [31:0] dev_wdata,
   input  logic        dev_rvalid,
   input  logic [31:0] dev_rdata,
   input  logic        dev_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

   localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

   state_t     state, state_nxt;
   logic [2:0] outstanding, outstanding_nxt;
   logic [2:0] discard, discard_nxt;
   logic [2:0] remaining;
   logic       full;
   logic       accept;
   logic       rsp;
   logic       rsp_fwd;
   logic       rsp_err;

`ifdef WB2CORE_ERR_EN
   assign rsp_err = dev_err;
`else
   logic unused_dev_err;
   assign unused_dev_err = dev_err;
   assign rsp_err        = 1'b0;
`endif

   assign full     = (outstanding == MAX_OUT);
   assign dev_req  = wb_cyc & wb_stb & ~full & (state != DRAIN);
   assign wb_stall = full | (state == DRAIN) | (wb_stb & ~dev_gnt);
   assign accept   = dev_req & dev_gnt;

   assign dev_addr  = wb_adr;
   assign dev_we    = wb_we;
   assign dev_be    = wb_sel;
   assign dev_wdata = wb_dat_i;

   // outstanding is forced to 0 while draining, so a stray rvalid with nothing
   // in flight (and every rvalid seen in DRAIN) never counts as a WB response.
   assign rsp     = dev_rvalid & (outstanding != 3'd0);
   assign rsp_fwd = rsp & wb_cyc & (state != DRAIN);

   assign remaining = outstanding - {2'b00, rsp};

   always_comb begin
      state_nxt       = state;
      outstanding_nxt = outstanding;
      discard_nxt     = discard;
      case (state)
         IDLE: begin
            if (accept) begin
               outstanding_nxt = 3'd1;
               state_nxt       = BUSY;
            end
         end
         BUSY: begin
            if (!wb_cyc) begin
               // Cycle abandoned: whatever did not return this cycle is discarded.
               outstanding_nxt = 3'd0;
               discard_nxt     = remaining;
               state_nxt       = (remaining != 3'd0) ? DRAIN : IDLE;
            end else begin
               outstanding_nxt = remaining + {2'b00, accept};
               if (outstanding_nxt == 3'd0) begin
                  state_nxt = IDLE;
               end
            end
         end
         DRAIN: begin
            if (discard == 3'd0) begin
               state_nxt = IDLE;
            end else if (dev_rvalid) begin
               discard_nxt = discard - 3'd1;
               if (discard == 3'd1) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt       = IDLE;
            outstanding_nxt = 3'd0;
            discard_nxt     = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         outstanding <= 3'd0;
         discard     <= 3'd0;
         wb_ack      <= 1'b0;
         wb_err      <= 1'b0;
         wb_dat_o    <= 32'h0;
      end else begin
         state       <= state_nxt;
         outstanding <= outstanding_nxt;
         discard     <= discard_nxt;
         wb_ack      <= rsp_fwd & ~rsp_err;
         wb_err      <= rsp_fwd & rsp_err;
         if (rsp_fwd) begin
            wb_dat_o <= rsp_err ? 32'h0 : dev_rdata;
         end
      end
   end

endmodule

// File: tb/tb_wb2core.sv
module tb_wb2core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_cyc, wb_stb, wb_we;
   logic [31:0] wb_adr, wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel;
   logic        wb_ack, wb_err, wb_stall;
   logic        dev_req, dev_gnt, dev_we;
   logic [3:0]  dev_be;
   logic [31:0] dev_addr, dev_wdata, dev_rdata;
   logic        dev_rvalid, dev_err;

   int n_cmp = 0;
   int n_bad = 0;

   wb2core #(.MAX_OUTSTANDING(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
      .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall),
      .dev_req(dev_req), .dev_gnt(dev_gnt), .dev_we(dev_we), .dev_be(dev_be),
      .dev_addr(dev_addr), .dev_wdata(dev_wdata),
      .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata), .dev_err(dev_err)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are sampled
   // 2 time units after it, well away from the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic quiet_inputs();
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = 32'h0;
      wb_sel = 4'hF; wb_dat_i = 32'h0; dev_gnt = 1'b1;
      dev_rvalid = 1'b0; dev_rdata = 32'h0; dev_err = 1'b0;
   endtask

   task automatic test_reset();
      quiet_inputs();
      rst_n = 1'b0;
      tick(); tick(); settle();
      n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0", wb_ack); end
      n_cmp++; if (wb_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", wb_err); end
      n_cmp++; if (wb_dat_o !== 32'h0) begin n_bad++; $display("FAIL reset_dat: got %h expected 0", wb_dat_o); end
      n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", wb_stall); end
      n_cmp++; if (dev_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b expected 0", dev_req); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_read();
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h100; wb_sel = 4'hF; dev_gnt = 1'b1;
      settle();
      n_cmp++; if (dev_req !== 1'b1) begin n_bad++; $display("FAIL rd_req: got %b expected 1", dev_req); end
      n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL rd_stall: got %b expected 0", wb_stall); end
      n_cmp++; if (dev_addr !== 32'h100) begin n_bad++; $display("FAIL rd_addr: got %h expected 100", dev_addr); end
      n_cmp++; if (dev_we !== 1'b0) begin n_bad++; $display("FAIL rd_we: got %b expected 0", dev_we); end
      tick();
      wb_stb = 1'b0; dev_rvalid = 1'b1; dev_rdata = 32'hDEADBEEF;
      settle();
      n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL rd_early_ack: got %b expected 0", wb_ack); end
      tick();
      dev_rvalid = 1'b0; dev_rdata = 32'h0;
      settle();
      n_cmp++; if (wb_ack !== 1'b1) begin n_bad++; $display("FAIL rd_ack: got %b expected 1", wb_ack); end
      n_cmp++; if (wb_dat_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h expected deadbeef", wb_dat_o); end
      n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL rd_stall_after: got %b expected 0", wb_stall); end
      tick(); settle();
      n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL rd_ack_single: got %b expected 0", wb_ack); end
      n_cmp++; if (wb_dat_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data_hold: got %h expected deadbeef", wb_dat_o); end
      wb_cyc = 1'b0;
      tick();
   endtask

   // Three writes, responses 3 cycles after each accept, limit of 2 in flight.
   task automatic test_burst();
      int acks = 0;
      logic [31:0] rsp_data [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
      logic        exp_ack;
      logic [31:0] exp_dat;
      wb_cyc = 1'b1; wb_we = 1'b1; wb_sel = 4'hF; dev_gnt = 1'b1;
      for (int c = 0; c <= 8; c++) begin
         wb_stb   = (c <= 4);
         wb_adr   = 32'h200 + 32'((c > 2 ? 2 : c) * 4);
         wb_dat_i = 32'hA000_0000 | wb_adr;
         dev_rvalid = (c == 3) || (c == 4) || (c == 7);
         dev_rdata  = (c == 3) ? rsp_data[0] : (c == 4) ? rsp_data[1] : (c == 7) ? rsp_data[2] : 32'h0;
         settle();
         if (c <= 4) begin
            n_cmp++;
            if (wb_stall !== ((c == 2) || (c == 3))) begin
               n_bad++; $display("FAIL burst_stall c%0d: got %b expected %b", c, wb_stall, ((c == 2) || (c == 3)));
            end
         end
         if (c == 4) begin
            n_cmp++; if (dev_addr !== 32'h208 || dev_wdata !== 32'hA000_0208) begin
               n_bad++; $display("FAIL burst_third_req: got %h/%h expected 208/a0000208", dev_addr, dev_wdata);
            end
         end
         tick();
         exp_ack = (c == 3) || (c == 4) || (c == 7);
         exp_dat = (c == 3) ? rsp_data[0] : (c == 4) ? rsp_data[1] : rsp_data[2];
         settle();
         n_cmp++; if (wb_ack !== exp_ack) begin n_bad++; $display("FAIL burst_ack c%0d: got %b expected %b", c, wb_ack, exp_ack); end
         if (wb_ack === 1'b1) acks++;
         if (exp_ack) begin
            n_cmp++; if (wb_dat_o !== exp_dat) begin n_bad++; $display("FAIL burst_data c%0d: got %h expected %h", c, wb_dat_o, exp_dat); end
         end
      end
      n_cmp++; if (acks != 3) begin n_bad++; $display("FAIL burst_ack_count: got %0d expected 3", acks); end
      quiet_inputs();
      tick();
   endtask

   task automatic test_gnt_stall();
      int stalls = 0;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'b0011;
      wb_adr = 32'h300; wb_dat_i = 32'hCAFE_0300; dev_gnt = 1'b0;
      for (int c = 0; c < 4; c++) begin
         settle();
         if (wb_stall === 1'b1) stalls++;
         n_cmp++; if (dev_be !== 4'b0011) begin n_bad++; $display("FAIL gnt_be c%0d: got %b expected 0011", c, dev_be); end
         tick();
         n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL gnt_early_ack c%0d: got %b expected 0", c, wb_ack); end
      end
      n_cmp++; if (stalls != 4) begin n_bad++; $display("FAIL gnt_stall_cycles: got %0d expected 4", stalls); end
      dev_gnt = 1'b1;
      settle();
      n_cmp++; if (wb_stall !== 1'b0 || dev_req !== 1'b1) begin
         n_bad++; $display("FAIL gnt_accept: got stall %b req %b expected 0 1", wb_stall, dev_req);
      end
      tick();
      wb_stb = 1'b0; dev_rvalid = 1'b1; dev_rdata = 32'h5555_0055;
      tick();
      dev_rvalid = 1'b0;
      settle();
      n_cmp++; if (wb_ack !== 1'b1) begin n_bad++; $display("FAIL gnt_ack: got %b expected 1", wb_ack); end
      tick(); settle();
      n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL gnt_one_ack: got %b expected 0", wb_ack); end
      quiet_inputs();
      tick();
   endtask

   task automatic test_drain();
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h400; dev_gnt = 1'b1;
      tick();
      wb_adr = 32'h404;
      tick();
      wb_cyc = 1'b0; wb_stb = 1'b0;
      tick(); settle();
      n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL drain_ack_drop: got %b expected 0", wb_ack); end
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 32'h500;
      for (int c = 0; c < 2; c++) begin
         dev_rvalid = 1'b1; dev_rdata = 32'hBAD0_0001 + 32'(c);
         settle();
         n_cmp++; if (wb_stall !== 1'b1) begin n_bad++; $display("FAIL drain_stall r%0d: got %b expected 1", c, wb_stall); end
         n_cmp++; if (dev_req !== 1'b0) begin n_bad++; $display("FAIL drain_req r%0d: got %b expected 0", c, dev_req); end
         tick(); settle();
         n_cmp++; if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin
            n_bad++; $display("FAIL drain_no_ack r%0d: got ack %b err %b expected 0 0", c, wb_ack, wb_err);
         end
      end
      n_cmp++; if (wb_dat_o !== 32'h5555_0055) begin n_bad++; $display("FAIL drain_dat_hold: got %h expected 55550055", wb_dat_o); end
      dev_rvalid = 1'b0;
      settle();
      n_cmp++; if (wb_stall !== 1'b0 || dev_req !== 1'b1) begin
         n_bad++; $display("FAIL drain_new_req: got stall %b req %b expected 0 1", wb_stall, dev_req);
      end
      tick();
      wb_stb = 1'b0; dev_rvalid = 1'b1; dev_rdata = 32'h600D_0500;
      tick();
      dev_rvalid = 1'b0;
      settle();
      n_cmp++; if (wb_ack !== 1'b1 || wb_dat_o !== 32'h600D_0500) begin
         n_bad++; $display("FAIL drain_new_ack: got ack %b data %h expected 1 600d0500", wb_ack, wb_dat_o);
      end
      quiet_inputs();
      tick();
   endtask

   task automatic test_err();
      logic        exp_ack, exp_err;
      logic [31:0] exp_dat;
`ifdef WB2CORE_ERR_EN
      exp_ack = 1'b0; exp_err = 1'b1; exp_dat = 32'h0;
`else
      exp_ack = 1'b1; exp_err = 1'b0; exp_dat = 32'h1234_5678;
`endif
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h700; dev_gnt = 1'b1;
      tick();
      wb_stb = 1'b0; dev_rvalid = 1'b1; dev_err = 1'b1; dev_rdata = 32'h1234_5678;
      tick();
      dev_rvalid = 1'b0; dev_err = 1'b0;
      settle();
      n_cmp++; if (wb_ack !== exp_ack) begin n_bad++; $display("FAIL err_ack: got %b expected %b", wb_ack, exp_ack); end
      n_cmp++; if (wb_err !== exp_err) begin n_bad++; $display("FAIL err_err: got %b expected %b", wb_err, exp_err); end
      n_cmp++; if (wb_dat_o !== exp_dat) begin n_bad++; $display("FAIL err_data: got %h expected %h", wb_dat_o, exp_dat); end
      tick(); settle();
      n_cmp++; if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin
         n_bad++; $display("FAIL err_pulse: got ack %b err %b expected 0 0", wb_ack, wb_err);
      end
      quiet_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h800; dev_gnt = 1'b1;
      tick();
      wb_adr = 32'h804;
      tick();
      wb_stb = 1'b0; rst_n = 1'b0;
      tick();
      rst_n = 1'b1; dev_rvalid = 1'b1; dev_rdata = 32'hDEAD_0800;
      settle();
      n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL rstmid_stall: got %b expected 0", wb_stall); end
      tick();
      dev_rvalid = 1'b0;
      settle();
      n_cmp++; if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_late_ack: got ack %b err %b expected 0 0", wb_ack, wb_err);
      end
      n_cmp++; if (wb_dat_o !== 32'h0) begin n_bad++; $display("FAIL rstmid_dat: got %h expected 0", wb_dat_o); end
      wb_stb = 1'b1; wb_adr = 32'h900;
      for (int c = 0; c < 2; c++) begin
         settle();
         n_cmp++; if (wb_stall !== 1'b0 || dev_req !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_accept%0d: got stall %b req %b expected 0 1", c, wb_stall, dev_req);
         end
         tick();
         wb_adr = 32'h904;
      end
      wb_stb = 1'b0;
      settle();
      n_cmp++; if (wb_stall !== 1'b1) begin n_bad++; $display("FAIL rstmid_full: got %b expected 1", wb_stall); end
      for (int c = 0; c < 2; c++) begin
         dev_rvalid = 1'b1; dev_rdata = 32'h0900_0000 + 32'(c);
         tick();
         settle();
         n_cmp++; if (wb_ack !== 1'b1 || wb_dat_o !== 32'h0900_0000 + 32'(c)) begin
            n_bad++; $display("FAIL rstmid_ack%0d: got ack %b data %h expected 1 %h", c, wb_ack, wb_dat_o, 32'h0900_0000 + 32'(c));
         end
      end
      dev_rvalid = 1'b0; wb_cyc = 1'b0;
      tick(); settle();
      n_cmp++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_end: got %b expected 0", wb_ack); end
      quiet_inputs();
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      quiet_inputs();
      test_reset();
      test_single_read();
      test_burst();
      test_gnt_stall();
      test_drain();
      test_err();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb2core.md
WB2CORE -- requirements
Module: wb2core

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning maximum WB requests accepted but not yet answered by the device (legal range 1..4).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have WB pipelined slave ports: wb_cyc in 1, wb_stb in 1, wb_we in 1, wb_adr in 32, wb_sel in 4, wb_dat_i in 32, wb_dat_o out 32, wb_ack out 1, wb_err out 1, wb_stall out 1.
REQ-005 SHALL have device (Ibex-style) master ports: dev_req out 1, dev_gnt in 1, dev_we out 1, dev_be out 4, dev_addr out 32, dev_wdata out 32, dev_rvalid in 1, dev_rdata in 32, dev_err in 1.

Function
REQ-006 SHALL keep a state machine IDLE (no outstanding), BUSY (1..MAX_OUTSTANDING outstanding), DRAIN (discarding responses of an abandoned cycle).
REQ-007 SHALL drive dev_req = wb_cyc & wb_stb & ~full & (state != DRAIN), where full = (outstanding == MAX_OUTSTANDING).
REQ-008 SHALL drive dev_addr=wb_adr, dev_we=wb_we, dev_be=wb_sel, dev_wdata=wb_dat_i combinationally.
REQ-009 SHALL drive wb_stall = full | (state == DRAIN) | (wb_stb & ~dev_gnt).
REQ-010 SHALL count a request accepted when dev_req & dev_gnt; outstanding +1 per accept, -1 per dev_rvalid, unchanged when both occur in one cycle.
REQ-011 SHALL register responses: one cycle after dev_rvalid with wb_cyc high and state != DRAIN, assert wb_ack (or wb_err, see REQ-019) for exactly one cycle, with wb_dat_o = dev_rdata sampled at dev_rvalid.
REQ-012 SHALL hold wb_dat_o at last captured value when no response; responses in order, one ack per accepted request.
REQ-013 SHALL, when wb_cyc falls with outstanding > 0, enter DRAIN with discard = outstanding minus any dev_rvalid in that same cycle; each later dev_rvalid decrements discard and produces no ack/err.
REQ-014 SHALL leave DRAIN to IDLE in the cycle discard reaches 0; new requests blocked until then.
REQ-015 SHALL transition IDLE->BUSY on accept, BUSY->IDLE when last outstanding response arrives without a same-cycle accept.
REQ-016 SHALL ignore dev_rvalid when outstanding == 0 (no ack, no counter underflow).
REQ-017 SHALL give read latency = device latency + 1 cycle; back-to-back accepts at one per cycle while dev_gnt high and not full.

Reset
REQ-018 SHALL, while rst_n low at a rising edge, set state IDLE, outstanding 0, discard 0, wb_ack 0, wb_err 0, wb_dat_o 0; reset mid-transaction abandons all outstanding responses without acks.

Configuration
REQ-019 SHALL honour macro WB2CORE_ERR_EN: defined -> dev_err sampled with dev_rvalid produces wb_err (not wb_ack) one cycle later, wb_dat_o = 0; undefined -> dev_err ignored, wb_err tied 0, every response is wb_ack.

Verification
REQ-020 Single read: adr 0x100, dev_gnt=1, dev_rvalid 1 cycle later with rdata 0xDEADBEEF -> wb_ack 1 cycle after rvalid, wb_dat_o=0xDEADBEEF, stall low.
REQ-021 Burst of 3 writes, MAX_OUTSTANDING=2, device response delayed 3 cycles -> third stb stalled until first rvalid; exactly 3 acks in order.
REQ-022 dev_gnt low 4 cycles on a write with sel=4'b0011 -> wb_stall high 4 cycles, dev_be=4'b0011 held, one accept, one ack.
REQ-023 Two reads outstanding, wb_cyc dropped, two rvalids follow -> state DRAIN, no acks, stall high until second rvalid, then new read accepted.
REQ-024 WB2CORE_ERR_EN defined, dev_err=1 with rvalid -> wb_err pulse, wb_ack 0; undefined -> wb_ack pulse, wb_err 0.
REQ-025 rst_n low with 2 outstanding -> next cycle outstanding 0, no ack from late rvalid, wb_stall low.
